// File: rtl/stop_button_pkg.sv
// rtl/stop_button_pkg.sv - shared state encoding and defaults for the stop-button conditioner
package stop_button_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous level
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/stop_button_conditioner.sv
// rtl/stop_button_conditioner.sv - synchronize, debounce and latch the stop button
module stop_button_conditioner
    import stop_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_raw,
    input  logic                rearm,
    output logic                stop_pulse,
    output logic                stop_level,
    output logic                stop_latched,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = {GLITCH_W{1'b1}};

    logic                btn_sync;
    btn_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pulse_q, pulse_d;
    logic                latched_q, latched_d;
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_hit;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            latched_q <= 1'b0;
            glitch_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            latched_q <= latched_d;
            glitch_q  <= glitch_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pulse_d    = 1'b0;
        glitch_hit = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (btn_sync) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!btn_sync) begin
                    state_d    = ST_IDLE;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HELD;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!btn_sync) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back high during release is not a new press: no pulse.
                if (btn_sync) begin
                    state_d    = ST_HELD;
                    glitch_hit = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set beats rearm so a press landing in the rearm cycle is never lost.
    assign latched_d = pulse_q | (latched_q & ~rearm);
    assign glitch_d  = (glitch_hit && (glitch_q != GLITCH_MAX)) ? glitch_q + 1'b1 : glitch_q;

    assign stop_pulse   = pulse_q;
    assign stop_level   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
    assign stop_latched = latched_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_stop_button_conditioner.sv
// tb/tb_stop_button_conditioner.sv - self-checking bench with run-length reference model
module tb_stop_button_conditioner;

    localparam int D0  = 4;
    localparam int D1  = 1;
    localparam int GW0 = 8;
    localparam int GW1 = 2;

    logic clk = 1'b0;
    logic reset, btn_raw, rearm;
    logic p0, l0, lt0;
    logic [GW0-1:0] g0;
    logic p1, l1, lt1;
    logic [GW1-1:0] g1;

    int checks   = 0;
    int failures = 0;

    int dcyc[2] = '{D0, D1};
    int gmax[2] = '{255, 3};
    int m_s1[2], m_s2[2], m_lvl[2], m_run[2], m_pulse[2], m_lat[2], m_gl[2];

    always #5 clk = ~clk;

    stop_button_conditioner #(.DEBOUNCE_CYCLES(D0), .GLITCH_W(GW0)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .rearm(rearm),
        .stop_pulse(p0), .stop_level(l0), .stop_latched(lt0), .glitch_count(g0)
    );

    stop_button_conditioner #(.DEBOUNCE_CYCLES(D1), .GLITCH_W(GW1)) dut1 (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .rearm(rearm),
        .stop_pulse(p1), .stop_level(l1), .stop_latched(lt1), .glitch_count(g1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // The level flips only after DEBOUNCE_CYCLES+1 consecutive synchronized samples
    // disagreeing with it; any broken non-empty disagreeing run is one glitch.
    task automatic model_edge(input int k, input logic r, input logic rm, input logic rst_n);
        int sync;
        int new_pulse;
        int new_lat;
        if (!rst_n) begin
            m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_run[k] = 0;
            m_pulse[k] = 0; m_lat[k] = 0; m_gl[k] = 0;
        end else begin
            sync      = m_s2[k];
            m_s2[k]   = m_s1[k];
            m_s1[k]   = int'(r);
            new_lat   = (m_pulse[k] != 0 || (m_lat[k] != 0 && !rm)) ? 1 : 0;
            new_pulse = 0;
            if (sync == m_lvl[k]) begin
                if (m_run[k] > 0 && m_gl[k] < gmax[k]) m_gl[k]++;
                m_run[k] = 0;
            end else begin
                m_run[k]++;
                if (m_run[k] == dcyc[k] + 1) begin
                    m_lvl[k] = sync;
                    m_run[k] = 0;
                    if (sync == 1) new_pulse = 1;
                end
            end
            m_pulse[k] = new_pulse;
            m_lat[k]   = new_lat;
        end
    endtask

    task automatic tick(input logic r, input logic rm, input logic rst_n);
        btn_raw = r;
        rearm   = rm;
        reset   = rst_n;
        @(posedge clk);
        model_edge(0, r, rm, rst_n);
        model_edge(1, r, rm, rst_n);
        #1;
        check("d4_pulse",   32'(p0),  m_pulse[0]);
        check("d4_level",   32'(l0),  m_lvl[0]);
        check("d4_latched", 32'(lt0), m_lat[0]);
        check("d4_glitch",  32'(g0),  m_gl[0]);
        check("d1_pulse",   32'(p1),  m_pulse[1]);
        check("d1_level",   32'(l1),  m_lvl[1]);
        check("d1_latched", 32'(lt1), m_lat[1]);
        check("d1_glitch",  32'(g1),  m_gl[1]);
    endtask

    initial begin
        int first_edge;
        int pulses;
        int g_before;
        logic r;
        int seg;

        // Reset with the button held high
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check("reset_pulse", 32'(p0), 0);
            check("reset_outputs", {29'd0, l0, lt0, 1'b0} | 32'(g0), 0);
        end
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1);

        // Clean press: pulse exactly once, right after edge 7
        first_edge = 0; pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (p0) begin pulses++; if (first_edge == 0) first_edge = i; end
        end
        check("press_pulse_edge", first_edge, 7);
        check("press_pulse_count", pulses, 1);
        check("press_level", 32'(l0), 1);
        check("press_latched", 32'(lt0), 1);

        // Release cleanly, clear the latch
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        check("rearm_clears", 32'(lt0), 0);

        // Press bounce: three short bursts are all rejected
        g_before = int'(g0); pulses = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 2; i++) begin tick(1'b1, 1'b0, 1'b1); if (p0) pulses++; end
            for (int i = 0; i < 3; i++) begin tick(1'b0, 1'b0, 1'b1); if (p0) pulses++; end
        end
        check("bounce_glitches", int'(g0) - g_before, 3);
        check("bounce_no_pulse", pulses, 0);
        check("bounce_level", 32'(l0), 0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1);

        // Release bounce while held
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, 1'b1);
        g_before = int'(g0); pulses = 0;
        for (int i = 0; i < 2; i++) begin tick(1'b0, 1'b0, 1'b1); if (p0) pulses++; end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (p0) pulses++;
            check("relbounce_level", 32'(l0), 1);
        end
        check("relbounce_glitch", int'(g0) - g_before, 1);
        check("relbounce_no_pulse", pulses, 0);
        first_edge = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            if (!l0 && first_edge == 0) first_edge = i;
        end
        check("release_fall_edge", first_edge, 7);

        // Rearm colliding with the pulse cycle: set wins
        tick(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) tick(1'b1, 1'b0, 1'b1);
        check("collide_pulse_up", 32'(p0), 1);
        tick(1'b1, 1'b1, 1'b1);
        check("collide_latched", 32'(lt0), 1);
        tick(1'b1, 1'b1, 1'b1);
        check("rearm_alone", 32'(lt0), 0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1);

        // Reset mid-debounce, then a fresh full debounce is required
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            check("midreset_cleared", {29'd0, p0, l0, lt0}, 0);
        end
        first_edge = 0; pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            if (p0) begin pulses++; if (first_edge == 0) first_edge = i; end
        end
        check("midreset_pulse_edge", first_edge, D0 + 3);
        check("midreset_pulse_count", pulses, 1);

        // Randomized runs of random length, occasional rearm and reset
        r = 1'b0; seg = 0;
        for (int i = 0; i < 4000; i++) begin
            if (seg == 0) begin
                r   = $urandom_range(0, 1) != 0;
                seg = $urandom_range(1, 9);
            end
            seg--;
            tick(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
